// File: rtl/safe_zone_pkg.sv
// Shared screen/map geometry and probe state encoding for the safe-zone map
// and its query-side initiators.
package safe_zone_pkg;

  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;
  localparam int BLOCK_SIZE    = 10;

  localparam int X_W    = $clog2(SCREEN_WIDTH);
  localparam int Y_W    = $clog2(SCREEN_HEIGHT);
  localparam int GRID_W = SCREEN_WIDTH / BLOCK_SIZE;
  localparam int GRID_H = SCREEN_HEIGHT / BLOCK_SIZE;
  localparam int BX_W   = $clog2(GRID_W);
  localparam int BY_W   = $clog2(GRID_H);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_HEIGHT - 1);
  localparam logic [X_W-1:0] BS_X  = X_W'(BLOCK_SIZE);
  localparam logic [Y_W-1:0] BS_Y  = Y_W'(BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SCAN     = 2'd2,
    DONE     = 2'd3
  } probe_state_t;

  function automatic logic [X_W-1:0] bx_to_px(input logic [BX_W-1:0] bx);
    return X_W'(bx) * BS_X;
  endfunction

  function automatic logic [Y_W-1:0] by_to_px(input logic [BY_W-1:0] by);
    return Y_W'(by) * BS_Y;
  endfunction

endpackage

// File: rtl/zone_span_calc.sv
// Converts a square box's top-left corner into the inclusive range of map
// blocks it covers, clamped to the screen so no query lands off-map.
module zone_span_calc
  import safe_zone_pkg::*;
#(
  parameter int PLAYER_SIZE = 20
) (
  input  logic [X_W-1:0]  x,
  input  logic [Y_W-1:0]  y,
  output logic [BX_W-1:0] bx0,
  output logic [BX_W-1:0] bx1,
  output logic [BY_W-1:0] by0,
  output logic [BY_W-1:0] by1
);

  localparam logic [X_W:0] EXT_X = (X_W+1)'(PLAYER_SIZE - 1);
  localparam logic [Y_W:0] EXT_Y = (Y_W+1)'(PLAYER_SIZE - 1);

  logic [X_W-1:0] x_c, x_e_c;
  logic [Y_W-1:0] y_c, y_e_c;
  logic [X_W:0]   x_e;
  logic [Y_W:0]   y_e;

  // Off-screen start coordinates are pulled in too, so bx0 never exceeds bx1.
  always_comb begin
    x_c   = (x > X_MAX) ? X_MAX : x;
    y_c   = (y > Y_MAX) ? Y_MAX : y;
    x_e   = {1'b0, x_c} + EXT_X;
    y_e   = {1'b0, y_c} + EXT_Y;
    x_e_c = (x_e > {1'b0, X_MAX}) ? X_MAX : x_e[X_W-1:0];
    y_e_c = (y_e > {1'b0, Y_MAX}) ? Y_MAX : y_e[Y_W-1:0];
    bx0   = BX_W'(x_c / BS_X);
    bx1   = BX_W'(x_e_c / BS_X);
    by0   = BY_W'(y_c / BS_Y);
    by1   = BY_W'(y_e_c / BS_Y);
  end

endmodule

// File: rtl/safe_zone_probe.sv
// Walks every map block under the player's box, queries the safe-zone map
// once per block and reports full / partial / no safe coverage.
//
// state    | meaning
// IDLE     | waiting for i_start
// WAIT_RDY | map regenerating; address parked on the first block
// SCAN     | one block sampled per ready edge, row-major
// DONE     | one-cycle o_done; results valid
module safe_zone_probe
  import safe_zone_pkg::*;
#(
  parameter  int PLAYER_SIZE = 20,
  localparam int MAX_BLK     = (PLAYER_SIZE / BLOCK_SIZE + 2) ** 2,
  localparam int CNT_W       = $clog2(MAX_BLK + 1)
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_start,
  input  logic [X_W-1:0]   i_player_x,
  input  logic [Y_W-1:0]   i_player_y,
  input  logic             i_zone_rdy,
  output logic [X_W-1:0]   o_zone_x,
  output logic [Y_W-1:0]   o_zone_y,
  input  logic             i_zone_is_safe,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_all_safe,
  output logic             o_any_safe,
  output logic [CNT_W-1:0] o_unsafe_cnt
);

  probe_state_t state, next_state;

  logic [BX_W-1:0]  bx0, bx1;
  logic [BY_W-1:0]  by0, by1;
  logic [X_W-1:0]   x_first, x_last;
  logic [Y_W-1:0]   y_first, y_last;
  logic [CNT_W-1:0] unsafe_acc, unsafe_nxt;
  logic             any_acc;
  logic             load, restart, sample, last_blk;

  zone_span_calc #(.PLAYER_SIZE(PLAYER_SIZE)) u_span (
    .x   (i_player_x),
    .y   (i_player_y),
    .bx0 (bx0),
    .bx1 (bx1),
    .by0 (by0),
    .by1 (by1)
  );

  assign last_blk   = (o_zone_x == x_last) && (o_zone_y == y_last);
  assign unsafe_nxt = unsafe_acc + {{(CNT_W-1){1'b0}}, ~i_zone_is_safe};
  assign o_busy     = (state == WAIT_RDY) || (state == SCAN);
  assign o_done     = (state == DONE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    restart    = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          load       = 1'b1;
          next_state = i_zone_rdy ? SCAN : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (i_zone_rdy) next_state = SCAN;
      end
      SCAN: begin
        if (!i_zone_rdy) begin
          restart    = 1'b1;
          next_state = WAIT_RDY;
        end else begin
          sample = 1'b1;
          if (last_blk) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A ready drop restarts from the first block so a result never mixes maps.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      x_first      <= '0;
      x_last       <= '0;
      y_first      <= '0;
      y_last       <= '0;
      o_zone_x     <= '0;
      o_zone_y     <= '0;
      unsafe_acc   <= '0;
      any_acc      <= 1'b0;
      o_unsafe_cnt <= '0;
      o_all_safe   <= 1'b0;
      o_any_safe   <= 1'b0;
    end else if (load) begin
      x_first    <= bx_to_px(bx0);
      x_last     <= bx_to_px(bx1);
      y_first    <= by_to_px(by0);
      y_last     <= by_to_px(by1);
      o_zone_x   <= bx_to_px(bx0);
      o_zone_y   <= by_to_px(by0);
      unsafe_acc <= '0;
      any_acc    <= 1'b0;
    end else if (restart) begin
      o_zone_x   <= x_first;
      o_zone_y   <= y_first;
      unsafe_acc <= '0;
      any_acc    <= 1'b0;
    end else if (sample) begin
      if (last_blk) begin
        o_unsafe_cnt <= unsafe_nxt;
        o_all_safe   <= (unsafe_nxt == '0);
        o_any_safe   <= any_acc | i_zone_is_safe;
      end else begin
        unsafe_acc <= unsafe_nxt;
        any_acc    <= any_acc | i_zone_is_safe;
        if (o_zone_x == x_last) begin
          o_zone_x <= x_first;
          o_zone_y <= o_zone_y + BS_Y;
        end else begin
          o_zone_x <= o_zone_x + BS_X;
        end
      end
    end
  end

endmodule

// File: tb/tb_safe_zone_probe.sv
// Directed bench for safe_zone_probe with a block-level map model driving
// i_zone_is_safe from the current query address.
module tb_safe_zone_probe;
  import safe_zone_pkg::*;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [X_W-1:0]   i_player_x = '0;
  logic [Y_W-1:0]   i_player_y = '0;
  logic             i_zone_rdy = 1'b0;
  logic [X_W-1:0]   o_zone_x;
  logic [Y_W-1:0]   o_zone_y;
  logic             i_zone_is_safe;
  logic             o_busy, o_done, o_all_safe, o_any_safe;
  logic [CNT_W-1:0] o_unsafe_cnt;

  bit unsafe_map [0:GRID_H-1][0:GRID_W-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign i_zone_is_safe = !unsafe_map[o_zone_y / BS_Y][o_zone_x / BS_X];

  safe_zone_probe #(.PLAYER_SIZE(20)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_start        (i_start),
    .i_player_x     (i_player_x),
    .i_player_y     (i_player_y),
    .i_zone_rdy     (i_zone_rdy),
    .o_zone_x       (o_zone_x),
    .o_zone_y       (o_zone_y),
    .i_zone_is_safe (i_zone_is_safe),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_all_safe     (o_all_safe),
    .o_any_safe     (o_any_safe),
    .o_unsafe_cnt   (o_unsafe_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_map();
    for (int r = 0; r < GRID_H; r++)
      for (int c = 0; c < GRID_W; c++)
        unsafe_map[r][c] = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_all_safe !== 1'b0 ||
        o_any_safe !== 1'b0 || o_unsafe_cnt !== 5'd0 ||
        o_zone_x !== 10'd0 || o_zone_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b all=%b any=%b cnt=%0d x=%0d y=%0d want all zero",
               o_busy, o_done, o_all_safe, o_any_safe, o_unsafe_cnt, o_zone_x, o_zone_y);
    end
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_aligned();
    int ex [4] = '{20, 30, 20, 30};
    int ey [4] = '{30, 30, 40, 40};
    clear_map();
    i_zone_rdy = 1'b1;
    i_player_x = 10'd20;
    i_player_y = 10'd30;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_zone_x !== X_W'(ex[k]) || o_zone_y !== Y_W'(ey[k])) begin
        errors++;
        $display("FAIL aligned_addr[%0d]: got (%0d,%0d) want (%0d,%0d)", k, o_zone_x, o_zone_y, ex[k], ey[k]);
      end
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL aligned_busy[%0d]: got busy=%b done=%b want busy=1 done=0", k, o_busy, o_done);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL aligned_done: got done=%b busy=%b want done=1 busy=0", o_done, o_busy);
    end
    checks++;
    if (o_all_safe !== 1'b1 || o_any_safe !== 1'b1 || o_unsafe_cnt !== 5'd0) begin
      errors++;
      $display("FAIL aligned_result: got all=%b any=%b cnt=%0d want all=1 any=1 cnt=0", o_all_safe, o_any_safe, o_unsafe_cnt);
    end
    tick();
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL aligned_done_pulse: got done=%b want 0", o_done);
    end
  endtask

  task automatic test_unaligned();
    clear_map();
    unsafe_map[1][2] = 1'b1;
    i_zone_rdy = 1'b1;
    i_player_x = 10'd15;
    i_player_y = 10'd5;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int by = 0; by <= 2; by++) begin
      for (int bx = 1; bx <= 3; bx++) begin
        checks++;
        if (o_zone_x !== X_W'(bx * 10) || o_zone_y !== Y_W'(by * 10) || o_done !== 1'b0) begin
          errors++;
          $display("FAIL unaligned_addr[%0d,%0d]: got (%0d,%0d) done=%b want (%0d,%0d) done=0",
                   bx, by, o_zone_x, o_zone_y, o_done, bx * 10, by * 10);
        end
        tick();
      end
    end
    checks++;
    if (o_done !== 1'b1 || o_unsafe_cnt !== 5'd1 || o_all_safe !== 1'b0 || o_any_safe !== 1'b1) begin
      errors++;
      $display("FAIL unaligned_result: got done=%b cnt=%0d all=%b any=%b want done=1 cnt=1 all=0 any=1",
               o_done, o_unsafe_cnt, o_all_safe, o_any_safe);
    end
    tick();
  endtask

  task automatic test_edge_clamp();
    clear_map();
    unsafe_map[59][79] = 1'b1;
    i_zone_rdy = 1'b1;
    i_player_x = 10'd790;
    i_player_y = 10'd590;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_zone_x !== 10'd790 || o_zone_y !== 10'd590 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL clamp_addr: got (%0d,%0d) busy=%b want (790,590) busy=1", o_zone_x, o_zone_y, o_busy);
    end
    tick();
    checks++;
    if (o_done !== 1'b1 || o_unsafe_cnt !== 5'd1 || o_all_safe !== 1'b0 || o_any_safe !== 1'b0) begin
      errors++;
      $display("FAIL clamp_result: got done=%b cnt=%0d all=%b any=%b want done=1 cnt=1 all=0 any=0",
               o_done, o_unsafe_cnt, o_all_safe, o_any_safe);
    end
    checks++;
    if (o_zone_x > 10'd799 || o_zone_y > 10'd599) begin
      errors++;
      $display("FAIL clamp_range: got (%0d,%0d) want within 799/599", o_zone_x, o_zone_y);
    end
    tick();
  endtask

  task automatic test_rdy_drop();
    int ex [4] = '{20, 30, 20, 30};
    int ey [4] = '{30, 30, 40, 40};
    clear_map();
    unsafe_map[3][2] = 1'b1;
    i_zone_rdy = 1'b1;
    i_player_x = 10'd20;
    i_player_y = 10'd30;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    checks++;
    if (o_zone_x !== 10'd20 || o_zone_y !== 10'd40) begin
      errors++;
      $display("FAIL drop_pre_addr: got (%0d,%0d) want (20,40)", o_zone_x, o_zone_y);
    end
    i_zone_rdy = 1'b0;
    clear_map();
    unsafe_map[4][3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_zone_x !== 10'd20 || o_zone_y !== 10'd30 || o_busy !== 1'b1 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold[%0d]: got (%0d,%0d) busy=%b done=%b want (20,30) busy=1 done=0",
                 k, o_zone_x, o_zone_y, o_busy, o_done);
      end
    end
    i_zone_rdy = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o_zone_x !== X_W'(ex[k]) || o_zone_y !== Y_W'(ey[k]) || o_done !== 1'b0) begin
        errors++;
        $display("FAIL drop_rescan[%0d]: got (%0d,%0d) done=%b want (%0d,%0d) done=0",
                 k, o_zone_x, o_zone_y, o_done, ex[k], ey[k]);
      end
      tick();
    end
    checks++;
    if (o_done !== 1'b1 || o_unsafe_cnt !== 5'd1 || o_all_safe !== 1'b0 || o_any_safe !== 1'b1) begin
      errors++;
      $display("FAIL drop_result: got done=%b cnt=%0d all=%b any=%b want done=1 cnt=1 all=0 any=1",
               o_done, o_unsafe_cnt, o_all_safe, o_any_safe);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_single_done: got done=%b busy=%b want 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_not_ready();
    clear_map();
    i_zone_rdy = 1'b0;
    i_player_x = 10'd20;
    i_player_y = 10'd30;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_zone_x !== 10'd20 || o_zone_y !== 10'd30) begin
        errors++;
        $display("FAIL notrdy_hold[%0d]: got busy=%b done=%b (%0d,%0d) want busy=1 done=0 (20,30)",
                 k, o_busy, o_done, o_zone_x, o_zone_y);
      end
      if (k < 4) tick();
    end
    i_zone_rdy = 1'b1;
    tick();
    checks++;
    if (o_zone_x !== 10'd20 || o_zone_y !== 10'd30) begin
      errors++;
      $display("FAIL notrdy_first: got (%0d,%0d) want (20,30)", o_zone_x, o_zone_y);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (o_done !== 1'b1 || o_unsafe_cnt !== 5'd0 || o_all_safe !== 1'b1 || o_any_safe !== 1'b1) begin
      errors++;
      $display("FAIL notrdy_result: got done=%b cnt=%0d all=%b any=%b want done=1 cnt=0 all=1 any=1",
               o_done, o_unsafe_cnt, o_all_safe, o_any_safe);
    end
    tick();
  endtask

  task automatic test_start_ignore_and_reset();
    clear_map();
    i_zone_rdy = 1'b1;
    i_player_x = 10'd15;
    i_player_y = 10'd5;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_start    = 1'b1;
    i_player_x = 10'd0;
    i_player_y = 10'd300;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_zone_x !== 10'd30 || o_zone_y !== 10'd0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_start: got (%0d,%0d) busy=%b want (30,0) busy=1", o_zone_x, o_zone_y, o_busy);
    end
    tick();
    arst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_all_safe !== 1'b0 || o_any_safe !== 1'b0 ||
        o_unsafe_cnt !== 5'd0 || o_zone_x !== 10'd0 || o_zone_y !== 10'd0) begin
      errors++;
      $display("FAIL midscan_reset: got busy=%b done=%b all=%b any=%b cnt=%0d (%0d,%0d) want all zero",
               o_busy, o_done, o_all_safe, o_any_safe, o_unsafe_cnt, o_zone_x, o_zone_y);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done[%0d]: got done=%b busy=%b want 0 0", k, o_done, o_busy);
      end
    end
    arst_n = 1'b1;
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got done=%b busy=%b want 0 0", o_done, o_busy);
    end
    i_player_x = 10'd790;
    i_player_y = 10'd590;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    checks++;
    if (o_done !== 1'b1 || o_unsafe_cnt !== 5'd0 || o_all_safe !== 1'b1 || o_any_safe !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_probe: got done=%b cnt=%0d all=%b any=%b want done=1 cnt=0 all=1 any=1",
               o_done, o_unsafe_cnt, o_all_safe, o_any_safe);
    end
    tick();
  endtask

  initial begin
    clear_map();
    test_reset();
    test_aligned();
    test_unaligned();
    test_edge_clamp();
    test_rdy_drop();
    test_not_ready();
    test_start_ignore_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
